// File: rtl/rabbit_word_assembler_pkg.sv
// Shared definitions for the Rabbit byte link and the DDS serial writer.
// Build option RABBIT_CHECKSUM_EN is consumed by rabbit_word_assembler.
package dds_link_pkg;

  localparam int unsigned NUM_BYTES = 23;
  localparam int unsigned WORD_W    = 8 * NUM_BYTES;

  // Field positions inside the assembled word, bit 0 = MSB of the first byte
  localparam int unsigned ADDR_LO  = 0;
  localparam int unsigned ADDR_HI  = 7;
  localparam int unsigned START_LO = 8;
  localparam int unsigned START_HI = 39;
  localparam int unsigned STOP_LO  = 40;
  localparam int unsigned STOP_HI  = 71;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    HOLD,
    DROP,
    WAITB,
    COMMIT
  } state_e;

endpackage

// File: rtl/rabbit_word_assembler_if.sv
// Parallel byte bus between the Rabbit microcontroller and the word assembler.
interface rabbit_word_assembler_if;
  logic [7:0] rabbit_data_0;
  logic       rabbit_strobe_0;
  logic       rabbit_frame_0;
  logic       rabbit_ack_0;

  modport master (
    output rabbit_data_0,
    output rabbit_strobe_0,
    output rabbit_frame_0,
    input  rabbit_ack_0
  );

  modport slave (
    input  rabbit_data_0,
    input  rabbit_strobe_0,
    input  rabbit_frame_0,
    output rabbit_ack_0
  );
endinterface

// File: rtl/rabbit_word_assembler_sync_edge_detect.sv
// Synchronizer chain for an asynchronous level, with single-cycle rise/fall pulses.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_rise = r_sync[STAGES-1] & ~r_dly;
  assign o_fall = ~r_sync[STAGES-1] & r_dly;

endmodule

// File: rtl/rabbit_word_assembler.sv
// Assembles Rabbit bytes into the DDS word and commits it atomically.
// Optional build macro: RABBIT_CHECKSUM_EN (trailing XOR byte per frame).
module rabbit_word_assembler
  import dds_link_pkg::*;
#(
  parameter int unsigned NUM_BYTES   = dds_link_pkg::NUM_BYTES,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   ten_MHz_ext_0,
  input  logic                   reset_0,
  rabbit_word_assembler_if.slave rabbit_bus,
  input  logic                   dds_busy_0,
  output logic [0:8*NUM_BYTES-1] full_184_bit_0,
  output logic                   word_valid_0,
  output logic                   frame_error_0,
  output logic [4:0]             byte_count_0
);

  localparam int unsigned WORD_BITS = 8 * NUM_BYTES;
`ifdef RABBIT_CHECKSUM_EN
  localparam int unsigned FRAME_BYTES = NUM_BYTES + 1;
`else
  localparam int unsigned FRAME_BYTES = NUM_BYTES;
`endif
  localparam logic [4:0] C_FULL = 5'(FRAME_BYTES);
  localparam logic [4:0] C_PAY  = 5'(NUM_BYTES);

  state_e                r_state, w_state_nxt;
  logic [0:WORD_BITS-1]  r_stage, r_word;
  logic                  r_valid, r_err, r_ack;
  logic [4:0]            r_count, w_cnt_eff;
  logic                  w_strobe_rise, w_strobe_fall, w_frame_rise, w_frame_fall;
  logic                  w_start, w_accept, w_set_err, w_csum_ok;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_strobe (
    .clk     (ten_MHz_ext_0),
    .rst     (reset_0),
    .i_async (rabbit_bus.rabbit_strobe_0),
    .o_rise  (w_strobe_rise),
    .o_fall  (w_strobe_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync_frame (
    .clk     (ten_MHz_ext_0),
    .rst     (reset_0),
    .i_async (rabbit_bus.rabbit_frame_0),
    .o_rise  (w_frame_rise),
    .o_fall  (w_frame_fall)
  );

`ifdef RABBIT_CHECKSUM_EN
  logic [7:0] r_xor;

  // Running XOR includes the checksum byte, so a good frame folds to zero
  always_ff @(posedge ten_MHz_ext_0 or posedge reset_0) begin
    if (reset_0)       r_xor <= '0;
    else if (w_start)  r_xor <= '0;
    else if (w_accept) r_xor <= r_xor ^ rabbit_bus.rabbit_data_0;
  end

  assign w_csum_ok = ((w_accept ? (r_xor ^ rabbit_bus.rabbit_data_0) : r_xor) == 8'h00);
`else
  assign w_csum_ok = 1'b1;
`endif

  always_ff @(posedge ten_MHz_ext_0 or posedge reset_0) begin
    if (reset_0) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_set_err   = 1'b0;
    w_cnt_eff   = r_count;
    unique case (r_state)
      IDLE: begin
        if (w_frame_rise) begin
          w_start     = 1'b1;
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        // A byte arriving with the frame fall is counted before the fall is judged
        if (w_strobe_rise) begin
          w_accept  = 1'b1;
          w_cnt_eff = r_count + 5'd1;
        end
        if (w_cnt_eff == C_FULL) begin
          if (!w_frame_fall)   w_state_nxt = HOLD;
          else if (!w_csum_ok) begin
            w_set_err   = 1'b1;
            w_state_nxt = IDLE;
          end else             w_state_nxt = dds_busy_0 ? WAITB : COMMIT;
        end else if (w_frame_fall) begin
          w_set_err   = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (w_strobe_rise) begin
          w_set_err   = 1'b1;
          w_state_nxt = w_frame_fall ? IDLE : DROP;
        end else if (w_frame_fall) begin
          if (!w_csum_ok) begin
            w_set_err   = 1'b1;
            w_state_nxt = IDLE;
          end else        w_state_nxt = dds_busy_0 ? WAITB : COMMIT;
        end
      end
      DROP: begin
        if (w_frame_fall) w_state_nxt = IDLE;
      end
      WAITB: begin
        if (!dds_busy_0) w_state_nxt = COMMIT;
      end
      COMMIT: begin
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ten_MHz_ext_0 or posedge reset_0) begin
    if (reset_0) begin
      r_stage <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ack   <= 1'b0;
      r_count <= '0;
    end else begin
      r_valid <= (r_state == COMMIT);
      if (r_state == COMMIT) r_word <= r_stage;

      if (w_start)       r_count <= '0;
      else if (w_accept) r_count <= w_cnt_eff;

      if (w_set_err)     r_err <= 1'b1;
      else if (w_start)  r_err <= 1'b0;

      if (w_accept)           r_ack <= 1'b1;
      else if (w_strobe_fall) r_ack <= 1'b0;

      if (w_accept && (r_count < C_PAY))
        r_stage <= {r_stage[8:WORD_BITS-1], rabbit_bus.rabbit_data_0};
    end
  end

  assign full_184_bit_0          = r_word;
  assign word_valid_0            = r_valid;
  assign frame_error_0           = r_err;
  assign byte_count_0            = r_count;
  assign rabbit_bus.rabbit_ack_0 = r_ack;

endmodule

// File: tb/tb_rabbit_word_assembler.sv
// Directed self-checking bench for rabbit_word_assembler.
module tb_rabbit_word_assembler;
  import dds_link_pkg::*;

  localparam int unsigned SYNC = 2;
`ifdef RABBIT_CHECKSUM_EN
  localparam int unsigned FLEN = NUM_BYTES + 1;
`else
  localparam int unsigned FLEN = NUM_BYTES;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              busy;
  logic [0:WORD_W-1] word;
  logic              valid;
  logic              err;
  logic [4:0]        cnt;

  rabbit_word_assembler_if bus ();

  always #50 clk = ~clk;

  rabbit_word_assembler #(
    .NUM_BYTES   (NUM_BYTES),
    .SYNC_STAGES (SYNC)
  ) dut (
    .ten_MHz_ext_0  (clk),
    .reset_0        (rst),
    .rabbit_bus     (bus),
    .dds_busy_0     (busy),
    .full_184_bit_0 (word),
    .word_valid_0   (valid),
    .frame_error_0  (err),
    .byte_count_0   (cnt)
  );

  int unsigned n_vec   = 0;
  int unsigned n_bad   = 0;
  int unsigned n_pulse = 0;
  int unsigned p0;
  logic [7:0]  fq[$];
  logic        hold_ok;

  always @(posedge clk) if (valid === 1'b1) n_pulse++;

  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic build_frame(input logic [7:0] base);
    logic [7:0] x;
    x = 8'h00;
    fq.delete();
    for (int k = 0; k < NUM_BYTES; k++) begin
      fq.push_back(base + 8'(k));
      x ^= base + 8'(k);
    end
`ifdef RABBIT_CHECKSUM_EN
    fq.push_back(x);
`endif
  endtask

  function automatic logic [0:WORD_W-1] exp_word(input logic [7:0] base);
    logic [0:WORD_W-1] w;
    for (int k = 0; k < NUM_BYTES; k++) w[8*k +: 8] = base + 8'(k);
    return w;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bus.rabbit_data_0   = b;
    tick(3);
    bus.rabbit_strobe_0 = 1'b1;
    tick(SYNC + 3);
    bus.rabbit_strobe_0 = 1'b0;
    tick(SYNC + 3);
  endtask

  task automatic send_bytes(input int unsigned first, input int unsigned n);
    for (int unsigned i = first; i < first + n; i++) send_byte(fq[i]);
  endtask

  task automatic open_frame;
    bus.rabbit_frame_0 = 1'b1;
    tick(SYNC + 3);
  endtask

  initial begin
    rst                 = 1'b1;
    busy                = 1'b0;
    bus.rabbit_data_0   = 8'h00;
    bus.rabbit_strobe_0 = 1'b0;
    bus.rabbit_frame_0  = 1'b0;
    tick(3);
    chk("rst_word",  word,  '0);
    chk("rst_valid", valid, 0);
    chk("rst_ack",   bus.rabbit_ack_0, 0);
    chk("rst_err",   err,   0);
    chk("rst_cnt",   cnt,   0);
    rst = 1'b0;
    tick(2);

    // good frame 0x01.., checks ack handshake and exact commit latency
    build_frame(8'h01);
    open_frame();
    bus.rabbit_data_0   = fq[0];
    tick(3);
    bus.rabbit_strobe_0 = 1'b1;
    tick(SYNC + 3);
    chk("ack_high", bus.rabbit_ack_0, 1);
    bus.rabbit_strobe_0 = 1'b0;
    tick(SYNC + 3);
    chk("ack_low",  bus.rabbit_ack_0, 0);
    chk("cnt_one",  cnt, 1);
    send_bytes(1, FLEN - 1);
    chk("cnt_full", cnt, FLEN);
    p0 = n_pulse;
    bus.rabbit_frame_0 = 1'b0;
    tick(SYNC + 1);
    chk("lat_early_valid", valid, 0);
    chk("lat_early_word",  word, '0);
    tick(1);
    chk("lat_valid",  valid, 1);
    chk("g1_word",    word, exp_word(8'h01));
    chk("g1_first",   word[0:7], 8'h01);
    chk("g1_last",    word[176:183], 8'h17);
    tick(1);
    chk("lat_pulse_end", valid, 0);
    chk("g1_pulses",  n_pulse - p0, 1);
    chk("g1_err",     err, 0);

    // short frame: 10 bytes then frame drop
    build_frame(8'hA0);
    p0 = n_pulse;
    open_frame();
    send_bytes(0, 10);
    bus.rabbit_frame_0 = 1'b0;
    tick(SYNC + 4);
    chk("short_err",    err, 1);
    chk("short_cnt",    cnt, 10);
    chk("short_word",   word, exp_word(8'h01));
    chk("short_pulses", n_pulse - p0, 0);

    // overrun: one byte too many, then a good frame clears the error
    build_frame(8'h30);
    p0 = n_pulse;
    open_frame();
    send_bytes(0, FLEN);
    send_byte(8'h55);
    chk("ovr_err", err, 1);
    bus.rabbit_frame_0 = 1'b0;
    tick(SYNC + 4);
    chk("ovr_pulses", n_pulse - p0, 0);
    chk("ovr_word",   word, exp_word(8'h01));
    chk("ovr_cnt",    cnt, FLEN);
    open_frame();
    chk("ovr_err_clr", err, 0);
    send_bytes(0, FLEN);
    bus.rabbit_frame_0 = 1'b0;
    tick(SYNC + 4);
    chk("rec_word",   word, exp_word(8'h30));
    chk("rec_pulses", n_pulse - p0, 1);
    chk("rec_err",    err, 0);

    // commit deferred while the writer is busy
    build_frame(8'h50);
    p0   = n_pulse;
    busy = 1'b1;
    open_frame();
    send_bytes(0, FLEN);
    bus.rabbit_frame_0 = 1'b0;
    hold_ok = 1'b1;
    for (int i = 0; i < 500; i++) begin
      tick(1);
      if (word !== exp_word(8'h30) || valid !== 1'b0) hold_ok = 1'b0;
    end
    chk("busy_hold", hold_ok, 1);
    busy = 1'b0;
    tick(1);
    chk("busy_rel_valid0", valid, 0);
    tick(1);
    chk("busy_rel_valid1", valid, 1);
    chk("busy_word", word, exp_word(8'h50));
    tick(2);
    chk("busy_pulses", n_pulse - p0, 1);

    // last strobe rise coincident with frame fall
    build_frame(8'h70);
    p0 = n_pulse;
    open_frame();
    send_bytes(0, FLEN - 1);
    bus.rabbit_data_0   = fq[FLEN-1];
    tick(3);
    bus.rabbit_strobe_0 = 1'b1;
    bus.rabbit_frame_0  = 1'b0;
    tick(SYNC + 3);
    bus.rabbit_strobe_0 = 1'b0;
    tick(SYNC + 3);
    chk("coin_word",   word, exp_word(8'h70));
    chk("coin_pulses", n_pulse - p0, 1);
    chk("coin_err",    err, 0);
    chk("coin_cnt",    cnt, FLEN);

`ifdef RABBIT_CHECKSUM_EN
    // corrupt checksum byte: error and no commit
    build_frame(8'h01);
    fq[NUM_BYTES] = fq[NUM_BYTES] ^ 8'hFF;
    p0 = n_pulse;
    open_frame();
    send_bytes(0, FLEN);
    bus.rabbit_frame_0 = 1'b0;
    tick(SYNC + 4);
    chk("csum_err",    err, 1);
    chk("csum_pulses", n_pulse - p0, 0);
    chk("csum_word",   word, exp_word(8'h70));
`endif

    // reset during a frame with the strobe high
    build_frame(8'h90);
    open_frame();
    send_bytes(0, 5);
    bus.rabbit_data_0   = fq[5];
    tick(3);
    bus.rabbit_strobe_0 = 1'b1;
    tick(SYNC + 3);
    chk("mid_ack", bus.rabbit_ack_0, 1);
    chk("mid_cnt", cnt, 6);
    rst = 1'b1;
    #1;
    chk("mrst_word",  word,  '0);
    chk("mrst_valid", valid, 0);
    chk("mrst_ack",   bus.rabbit_ack_0, 0);
    chk("mrst_err",   err,   0);
    chk("mrst_cnt",   cnt,   0);
    bus.rabbit_strobe_0 = 1'b0;
    bus.rabbit_frame_0  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(SYNC + 4);
    chk("post_rst_word", word, '0);
    chk("post_rst_cnt",  cnt,  0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
